// File: rtl/bcd_channel_scheduler_pkg.sv
// Shared constants, state encoding and BCD pointer arithmetic for the
// round-robin scheduler in front of the 23-output BCD decoder.
package bcd_channel_scheduler_pkg;

    localparam int unsigned N_CH         = 23;
    localparam logic [7:0]  CODE_PREFIX  = 8'h01;
    localparam logic [3:0]  BCD_TENS_MAX = 4'd2;
    localparam logic [3:0]  BCD_ONES_TOP = 4'd2;
    localparam logic [15:0] IDLE_CODE    = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GRANT = 2'd2
    } state_e;

    // Successor of a two-digit BCD channel number, wrapping 22 -> 00.
    function automatic logic [7:0] bcd_next(input logic [3:0] tens, input logic [3:0] ones);
        logic [7:0] nxt;
        if ((tens == BCD_TENS_MAX) && (ones == BCD_ONES_TOP)) begin
            nxt = 8'h00;
        end else if (ones == 4'd9) begin
            nxt = {tens + 4'd1, 4'd0};
        end else begin
            nxt = {tens, ones + 4'd1};
        end
        return nxt;
    endfunction

    // Successor of the binary mirror, wrapping at the last channel.
    function automatic logic [4:0] bin_next(input logic [4:0] bin);
        logic [4:0] nxt;
        if (bin == 5'(N_CH - 1)) begin
            nxt = 5'd0;
        end else begin
            nxt = bin + 5'd1;
        end
        return nxt;
    endfunction

    function automatic logic [N_CH-1:0] chan_onehot(input logic [4:0] idx);
        return {{(N_CH-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/bcd_channel_scheduler_ptr_counter.sv
// Two-digit BCD channel pointer (00..22) with a binary mirror; supports
// load, increment, or load-then-increment in a single cycle.
module bcd_ptr_counter
    import bcd_channel_scheduler_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld,
    input  logic [3:0] ld_tens,
    input  logic [3:0] ld_ones,
    input  logic [4:0] ld_bin,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic [4:0] bin
);

    logic [3:0] tens_r, ones_r;
    logic [4:0] bin_r;
    logic [3:0] base_tens_s, base_ones_s;
    logic [4:0] base_bin_s;
    logic [7:0] bcd_succ_s;
    logic [3:0] next_tens_s, next_ones_s;
    logic [4:0] next_bin_s;

    // Select load value or current pointer, then optionally step it.
    always_comb begin
        base_tens_s = tens_r;
        base_ones_s = ones_r;
        base_bin_s  = bin_r;
        if (ld) begin
            base_tens_s = ld_tens;
            base_ones_s = ld_ones;
            base_bin_s  = ld_bin;
        end else begin
            base_tens_s = tens_r;
            base_ones_s = ones_r;
            base_bin_s  = bin_r;
        end
        bcd_succ_s = bcd_next(base_tens_s, base_ones_s);
        if (inc) begin
            next_tens_s = bcd_succ_s[7:4];
            next_ones_s = bcd_succ_s[3:0];
            next_bin_s  = bin_next(base_bin_s);
        end else begin
            next_tens_s = base_tens_s;
            next_ones_s = base_ones_s;
            next_bin_s  = base_bin_s;
        end
    end

    // Pointer register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tens_r <= 4'd0;
            ones_r <= 4'd0;
            bin_r  <= 5'd0;
        end else begin
            tens_r <= next_tens_s;
            ones_r <= next_ones_s;
            bin_r  <= next_bin_s;
        end
    end

    assign tens = tens_r;
    assign ones = ones_r;
    assign bin  = bin_r;

endmodule

// File: rtl/bcd_channel_scheduler.sv
// Round-robin scheduler sharing the BCD decoder among 23 request lines;
// emits {8'h01, tens, ones} for the granted channel with a minimum hold.
module bcd_channel_scheduler
    import bcd_channel_scheduler_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_CH-1:0]  req,
    input  logic             clr_all,
    input  logic             ack,
    output logic [15:0]      code,
    output logic             code_valid,
    output logic [4:0]       grant_idx,
    output logic [N_CH-1:0]  pending,
    output logic             busy
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_e          state_r;
    logic [N_CH-1:0] pending_r;
    logic [7:0]      timer_r;
    logic [3:0]      grant_tens_r, grant_ones_r;
    logic [4:0]      grant_bin_r;
    logic [15:0]     code_r;
    logic            code_valid_r;
    logic [4:0]      grant_idx_r;
    logic            busy_r;

    logic [3:0]      ptr_tens_s, ptr_ones_s;
    logic [4:0]      ptr_bin_s;
    logic            hit_s;
    logic            done_s;
    logic            ptr_inc_s;
    logic [N_CH-1:0] clear_mask_s;
    logic [N_CH-1:0] pending_next_s;

    // Grant completion, served-bit clear and pointer stepping decisions.
    always_comb begin
        hit_s  = |(pending_r & chan_onehot(ptr_bin_s));
        done_s = (state_r == ST_GRANT) && (timer_r == 8'd0) && ack;
        if (done_s) begin
            clear_mask_s = chan_onehot(grant_bin_r);
        end else begin
            clear_mask_s = {N_CH{1'b0}};
        end
        // A request arriving for the channel being cleared must survive.
        if (clr_all) begin
            pending_next_s = req;
        end else begin
            pending_next_s = (pending_r & ~clear_mask_s) | req;
        end
        ptr_inc_s = done_s ||
                    ((state_r == ST_SCAN) && !hit_s && (pending_r != {N_CH{1'b0}}));
    end

    bcd_ptr_counter u_ptr (
        .clk     (clk),
        .reset_n (reset_n),
        .ld      (done_s),
        .ld_tens (grant_tens_r),
        .ld_ones (grant_ones_r),
        .ld_bin  (grant_bin_r),
        .inc     (ptr_inc_s),
        .tens    (ptr_tens_s),
        .ones    (ptr_ones_s),
        .bin     (ptr_bin_s)
    );

    // Pending request latch.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pending_r <= {N_CH{1'b0}};
        end else begin
            pending_r <= pending_next_s;
        end
    end

    // Scheduler FSM with registered grant outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            timer_r      <= 8'd0;
            grant_tens_r <= 4'd0;
            grant_ones_r <= 4'd0;
            grant_bin_r  <= 5'd0;
            code_r       <= IDLE_CODE;
            code_valid_r <= 1'b0;
            grant_idx_r  <= 5'd0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pending_r != {N_CH{1'b0}}) begin
                        state_r <= ST_SCAN;
                        busy_r  <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (pending_r == {N_CH{1'b0}}) begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (hit_s) begin
                        state_r      <= ST_GRANT;
                        timer_r      <= HOLD_LOAD;
                        grant_tens_r <= ptr_tens_s;
                        grant_ones_r <= ptr_ones_s;
                        grant_bin_r  <= ptr_bin_s;
                        code_r       <= {CODE_PREFIX, ptr_tens_s, ptr_ones_s};
                        code_valid_r <= 1'b1;
                        grant_idx_r  <= ptr_bin_s;
                    end
                end
                ST_GRANT: begin
                    if (done_s) begin
                        code_r       <= IDLE_CODE;
                        code_valid_r <= 1'b0;
                        grant_idx_r  <= 5'd0;
                        if (pending_next_s != {N_CH{1'b0}}) begin
                            state_r <= ST_SCAN;
                            busy_r  <= 1'b1;
                        end else begin
                            state_r <= ST_IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else if (timer_r != 8'd0) begin
                        timer_r <= timer_r - 8'd1;
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    timer_r      <= 8'd0;
                    code_r       <= IDLE_CODE;
                    code_valid_r <= 1'b0;
                    grant_idx_r  <= 5'd0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign code       = code_r;
    assign code_valid = code_valid_r;
    assign grant_idx  = grant_idx_r;
    assign pending    = pending_r;
    assign busy       = busy_r;

endmodule

// File: tb/tb_bcd_channel_scheduler.sv
// Directed bench for bcd_channel_scheduler with hand-computed grant codes,
// latencies and hold durations (HOLD_CYCLES = 4).
module tb_bcd_channel_scheduler;

    logic        clk;
    logic        reset_n;
    logic [22:0] req;
    logic        clr_all;
    logic        ack;
    logic [15:0] code;
    logic        code_valid;
    logic [4:0]  grant_idx;
    logic [22:0] pending;
    logic        busy;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    bcd_channel_scheduler #(.HOLD_CYCLES(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .clr_all    (clr_all),
        .ack        (ack),
        .code       (code),
        .code_valid (code_valid),
        .grant_idx  (grant_idx),
        .pending    (pending),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Ticks until code_valid rises; n = number of edges taken.
    task automatic wait_valid(input string tag, output int n);
        n = 0;
        while (!code_valid && n < 60) begin
            tick();
            n++;
        end
        if (!code_valid) check({tag, "_timeout"}, {31'd0, code_valid}, 32'd1);
    endtask

    // Ticks until code_valid falls; n = number of cycles it stayed high.
    task automatic count_valid(output int n);
        n = 0;
        while (code_valid && n < 100) begin
            tick();
            n++;
        end
    endtask

    function automatic logic [22:0] bit_of(input int i);
        logic [22:0] one;
        one = 23'd1;
        return one << i;
    endfunction

    logic [15:0] exp_code_a [3] = '{16'h0103, 16'h0117, 16'h0122};
    logic [4:0]  exp_idx_a  [3] = '{5'd3, 5'd17, 5'd22};
    logic [15:0] exp_code_b [2] = '{16'h0100, 16'h0121};
    logic [4:0]  exp_idx_b  [2] = '{5'd0, 5'd21};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset_n = 1'b0; req = 23'd0; clr_all = 1'b0; ack = 1'b0;
        repeat (2) tick();
        check("rst_code",    32'(code), 32'h0);
        check("rst_valid",   32'(code_valid), 32'd0);
        check("rst_idx",     32'(grant_idx), 32'd0);
        check("rst_pending", 32'(pending), 32'd0);
        check("rst_busy",    32'(busy), 32'd0);
        reset_n = 1'b1;
        tick();

        // Single request on channel 5, ack tied high
        ack = 1'b1; req = bit_of(5);
        tick();
        req = 23'd0;
        check("t1_pending", 32'(pending), 32'(bit_of(5)));
        wait_valid("t1", n);
        check("t1_latency", n, 7);
        check("t1_code", 32'(code), 32'h0105);
        check("t1_idx", 32'(grant_idx), 32'd5);
        count_valid(n);
        check("t1_hold", n, 4);
        check("t1_pending_clr", 32'(pending), 32'd0);
        check("t1_code_idle", 32'(code), 32'h0);
        check("t1_busy", 32'(busy), 32'd0);

        // Fresh reset, then three simultaneous requests served in order
        reset_n = 1'b0; #2; reset_n = 1'b1;
        tick();
        req = bit_of(3) | bit_of(17) | bit_of(22);
        tick();
        req = 23'd0;
        for (int i = 0; i < 3; i++) begin
            wait_valid("t2", n);
            check("t2_code", 32'(code), 32'(exp_code_a[i]));
            check("t2_idx", 32'(grant_idx), 32'(exp_idx_a[i]));
            count_valid(n);
            check("t2_hold", n, 4);
        end
        check("t2_busy", 32'(busy), 32'd0);

        // Pointer wrapped past 22: channel 0 before channel 21
        req = bit_of(0) | bit_of(21);
        tick();
        req = 23'd0;
        for (int i = 0; i < 2; i++) begin
            wait_valid("t3", n);
            check("t3_code", 32'(code), 32'(exp_code_b[i]));
            check("t3_idx", 32'(grant_idx), 32'(exp_idx_b[i]));
            count_valid(n);
        end

        // Channel 12 held by a slow consumer; early ack pulse ignored
        ack = 1'b0; req = bit_of(12);
        tick();
        req = 23'd0;
        wait_valid("t4", n);
        check("t4_code", 32'(code), 32'h0112);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("t4_early_ack", 32'(code_valid), 32'd1);
        for (int i = 0; i < 9; i++) begin
            tick();
            check("t4_hold_code", 32'(code), 32'h0112);
        end
        ack = 1'b1;
        tick();
        check("t4_release_valid", 32'(code_valid), 32'd0);
        check("t4_release_code", 32'(code), 32'h0);

        // Re-request of channel 8 in its own completion cycle survives
        req = bit_of(8);
        tick();
        req = 23'd0;
        wait_valid("t5", n);
        check("t5_code", 32'(code), 32'h0108);
        repeat (3) tick();
        check("t5_still_valid", 32'(code_valid), 32'd1);
        req = bit_of(8);
        tick();
        req = 23'd0;
        check("t5_done", 32'(code_valid), 32'd0);
        check("t5_pending", 32'(pending), 32'(bit_of(8)));
        check("t5_busy", 32'(busy), 32'd1);
        wait_valid("t5b", n);
        check("t5_full_scan", n, 23);
        check("t5_regrant", 32'(code), 32'h0108);
        count_valid(n);
        check("t5_hold", n, 4);

        // clr_all together with req[4]
        ack = 1'b0; req = bit_of(10) | bit_of(15);
        tick();
        check("t5_pend2", 32'(pending), 32'(bit_of(10) | bit_of(15)));
        clr_all = 1'b1; req = bit_of(4);
        tick();
        clr_all = 1'b0; req = 23'd0;
        check("t5_clr_all", 32'(pending), 32'(bit_of(4)));
        ack = 1'b1;
        wait_valid("t5c", n);
        check("t5_code4", 32'(code), 32'h0104);
        count_valid(n);

        // Asynchronous reset in the middle of a grant on channel 20
        ack = 1'b0; req = bit_of(20);
        tick();
        req = 23'd0;
        wait_valid("t6", n);
        check("t6_code", 32'(code), 32'h0120);
        #2; reset_n = 1'b0;
        #1;
        check("t6_rst_code", 32'(code), 32'h0);
        check("t6_rst_valid", 32'(code_valid), 32'd0);
        check("t6_rst_pending", 32'(pending), 32'd0);
        #1; reset_n = 1'b1;
        tick();
        check("t6_busy", 32'(busy), 32'd0);
        ack = 1'b1; req = bit_of(0);
        tick();
        req = 23'd0;
        wait_valid("t6b", n);
        check("t6_ptr_zero_lat", n, 2);
        check("t6_code0", 32'(code), 32'h0100);
        count_valid(n);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
